// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder-subtractor. The carry chain is split into
// SEG-bit segments with one segment per stage, and the carry is registered
// between stages. Optional signed saturation is applied in the final stage.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned STAGES   = WIDTH / SEG;
  localparam int unsigned LAST_LSB = (STAGES - 1) * SEG;

  // Adds segment k of x and (y ^ inv) with carry-in; returns {carry_out, sum}.
  function automatic logic [SEG:0] seg_add(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic inv, input logic cin,
                                           input int unsigned k);
    logic [SEG-1:0] xs;
    logic [SEG-1:0] ys;
    xs = SEG'(x >> (k * SEG));
    ys = SEG'(y >> (k * SEG)) ^ {SEG{inv}};
    return (SEG+1)'(xs) + (SEG+1)'(ys) + (SEG+1)'(cin);
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             adv_c;
  logic             acc_c;

  // Operands and partial result presented to the final segment.
  logic [WIDTH-1:0] fin_a_c, fin_b_c, fin_res_c;
  logic             fin_sub_c, fin_sat_c, fin_cin_c, fin_vld_c;

  assign adv_c    = !out_valid_q || out_ready;
  assign in_ready = adv_c && !reset;
  assign acc_c    = in_valid && in_ready;

  if (STAGES == 1) begin : g_single
    assign fin_a_c   = a;
    assign fin_b_c   = b;
    assign fin_sub_c = sub;
    assign fin_sat_c = sat;
    assign fin_res_c = '0;
    assign fin_cin_c = sub;
    assign fin_vld_c = acc_c;
  end else begin : g_multi
    localparam int unsigned NP = STAGES - 1;

    logic [WIDTH-1:0] a_q   [NP];
    logic [WIDTH-1:0] a_d   [NP];
    logic [WIDTH-1:0] b_q   [NP];
    logic [WIDTH-1:0] b_d   [NP];
    logic [WIDTH-1:0] res_q [NP];
    logic [WIDTH-1:0] res_d [NP];
    logic [NP-1:0]    sub_q, sub_d, sat_q, sat_d, cy_q, cy_d, vld_q, vld_d;

    // Lower segments: add one slice per stage, skew finished bits and operands forward.
    always_comb begin
      logic [SEG:0] seg;
      seg   = '0;
      a_d   = a_q;
      b_d   = b_q;
      res_d = res_q;
      sub_d = sub_q;
      sat_d = sat_q;
      cy_d  = cy_q;
      vld_d = vld_q;

      seg      = seg_add(a, b, sub, sub, 0);
      a_d[0]   = a;
      b_d[0]   = b;
      sub_d[0] = sub;
      sat_d[0] = sat;
      res_d[0] = WIDTH'(seg[SEG-1:0]);
      cy_d[0]  = seg[SEG];
      vld_d[0] = acc_c;

      for (int unsigned k = 1; k < NP; k++) begin
        seg      = seg_add(a_q[k-1], b_q[k-1], sub_q[k-1], cy_q[k-1], k);
        a_d[k]   = a_q[k-1];
        b_d[k]   = b_q[k-1];
        sub_d[k] = sub_q[k-1];
        sat_d[k] = sat_q[k-1];
        res_d[k] = res_q[k-1] | (WIDTH'(seg[SEG-1:0]) << (k * SEG));
        cy_d[k]  = seg[SEG];
        vld_d[k] = vld_q[k-1];
      end
    end

    // Intermediate stage registers; all hold while the output is stalled.
    always_ff @(posedge clk) begin
      if (reset) begin
        a_q   <= '{default: '0};
        b_q   <= '{default: '0};
        res_q <= '{default: '0};
        sub_q <= '0;
        sat_q <= '0;
        cy_q  <= '0;
        vld_q <= '0;
      end else if (adv_c) begin
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
        sub_q <= sub_d;
        sat_q <= sat_d;
        cy_q  <= cy_d;
        vld_q <= vld_d;
      end
    end

    assign fin_a_c   = a_q[NP-1];
    assign fin_b_c   = b_q[NP-1];
    assign fin_sub_c = sub_q[NP-1];
    assign fin_sat_c = sat_q[NP-1];
    assign fin_res_c = res_q[NP-1];
    assign fin_cin_c = cy_q[NP-1];
    assign fin_vld_c = vld_q[NP-1];
  end

  // Final segment: top slice, flags from the true sum, then saturation and zero.
  always_comb begin
    logic [SEG:0]     seg;
    logic [WIDTH-1:0] raw;
    logic             cin_msb;
    seg     = seg_add(fin_a_c, fin_b_c, fin_sub_c, fin_cin_c, STAGES - 1);
    raw     = fin_res_c | (WIDTH'(seg[SEG-1:0]) << LAST_LSB);
    cin_msb = fin_a_c[WIDTH-1] ^ fin_b_c[WIDTH-1] ^ fin_sub_c ^ raw[WIDTH-1];

    carry_d     = seg[SEG];
    ovf_d       = cin_msb ^ seg[SEG];
    out_valid_d = fin_vld_c;
    sum_d       = raw;
    if (fin_sat_c && ovf_d) begin
      sum_d = fin_a_c[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    zero_d = (sum_d == '0);
  end

  // Output register stage; held while downstream is not ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (adv_c) begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
